// File: rtl/spi_echo_buffer.sv
// SPI loopback controller: echoes the last word or a FIFO head back to the master and exposes status.
// Optional: define SPI_ECHO_CHECKSUM_EN to show a running XOR of all received words on disp_sel=3.
module spi_echo_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int DISP_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spi_ready,
    input  logic [DATA_WIDTH-1:0]   spi_data_in,
    output logic [DATA_WIDTH-1:0]   spi_data_out,
    input  logic                    mode,
    input  logic                    freeze,
    input  logic [1:0]              disp_sel,
    output logic [DISP_WIDTH-1:0]   disp,
    output logic [CNT_WIDTH-1:0]    xfer_count,
    output logic [$clog2(DEPTH):0]  fill,
    output logic                    overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;
    localparam logic [FW-1:0] FULL = FW'(DEPTH);

    logic                  r_armed;
    logic [DATA_WIDTH-1:0] r_last;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [FW-1:0]         r_fill;
    logic                  r_ovf;
    logic [DATA_WIDTH-1:0] r_out;

    logic                  w_event;
    logic                  w_pop;
    logic                  w_push;
    logic [PW-1:0]         w_rd_nxt;
    logic [FW-1:0]         w_fill_nxt;
    logic [DATA_WIDTH-1:0] w_last_nxt;
    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic [DATA_WIDTH-1:0] w_head;
    logic [DISP_WIDTH-1:0] w_disp;

    function automatic logic [DISP_WIDTH-1:0] fit_disp(input logic [63:0] v);
        return v[DISP_WIDTH-1:0];
    endfunction

    assign w_event    = spi_ready & r_armed;
    assign w_pop      = w_event & mode & ~freeze & (r_fill != '0);
    // A full FIFO still accepts a word when the same event pops the head.
    assign w_push     = w_event & ((r_fill != FULL) | w_pop);
    assign w_rd_nxt   = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
    assign w_fill_nxt = r_fill + FW'(w_push) - FW'(w_pop);
    assign w_last_nxt = w_event ? spi_data_in : r_last;
    // The next head may be the word being written this cycle, which is not in r_mem yet.
    assign w_head_nxt = (w_push && (w_rd_nxt == r_wr_ptr)) ? spi_data_in : r_mem[w_rd_nxt];
    assign w_head     = (r_fill != '0) ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed  <= 1'b0;
            r_last   <= '0;
            r_cnt    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_ovf    <= 1'b0;
            r_out    <= '0;
        end else begin
            if (!spi_ready) begin
                r_armed <= 1'b1;
            end else if (w_event) begin
                r_armed <= 1'b0;
            end
            if (w_event) begin
                r_last <= spi_data_in;
                r_cnt  <= r_cnt + CNT_WIDTH'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_event && !w_push) begin
                r_ovf <= 1'b1;
            end
            r_rd_ptr <= w_rd_nxt;
            r_fill   <= w_fill_nxt;
            r_out    <= mode ? ((w_fill_nxt != '0) ? w_head_nxt : '0) : w_last_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= spi_data_in;
        end
    end

`ifdef SPI_ECHO_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_chk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk <= '0;
        end else if (w_event) begin
            r_chk <= r_chk ^ spi_data_in;
        end
    end
`endif

    always_comb begin
        w_disp = '0;
        case (disp_sel)
            2'd0:    w_disp = fit_disp(64'(r_last));
            2'd1:    w_disp = fit_disp(64'(r_cnt));
            2'd2:    w_disp = fit_disp(64'(r_fill));
`ifdef SPI_ECHO_CHECKSUM_EN
            default: w_disp = fit_disp(64'(r_chk));
`else
            default: w_disp = fit_disp(64'(w_head));
`endif
        endcase
    end

    assign spi_data_out = r_out;
    assign xfer_count   = r_cnt;
    assign fill         = r_fill;
    assign overflow     = r_ovf;
    assign disp         = w_disp;
endmodule
